// File: rtl/pio_out_blink_pkg.sv
// Shared constants for the blinking output PIO: register word addresses.
package pio_out_blink_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLR      = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
    localparam logic [2:0] ADDR_PERIOD   = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;

endpackage

// File: rtl/pio_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
module pio_tick_gen #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] cnt_q;

    assign tick = (cnt_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with SET/CLEAR aliases, registered readback and per-bit blink.
module pio_out_blink
    import pio_out_blink_pkg::*;
#(
    parameter int unsigned        DATA_W      = 10,
    parameter logic [DATA_W-1:0]  RESET_VALUE = '0,
    parameter int unsigned        PRESCALE    = 50000,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] blink_en_q;
    logic [CNT_W-1:0]  period_q;
    logic [CNT_W-1:0]  bcnt_q;
    logic              phase_q;
    logic [31:0]       rd_mux;
    logic              tick;

    logic wr_en, rd_en, period_wr;
    logic [DATA_W-1:0] wd_data;
    logic [CNT_W-1:0]  wd_cnt;

    assign wr_en     = chipselect & ~write_n;
    assign rd_en     = chipselect & ~read_n;
    assign period_wr = wr_en && (address == ADDR_PERIOD);
    assign wd_data   = writedata[DATA_W-1:0];
    assign wd_cnt    = writedata[CNT_W-1:0];

    pio_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            unique case (address)
                ADDR_DATA: data_d = wd_data;
                ADDR_SET:  data_d = data_q | wd_data;
                ADDR_CLR:  data_d = data_q & ~wd_data;
                default:   data_d = data_q;
            endcase
        end
    end

    // Read mux sees pre-edge state, so a simultaneous write returns the old value.
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR: rd_mux = 32'(data_q);
            ADDR_BLINK_EN:                 rd_mux = 32'(blink_en_q);
            ADDR_PERIOD:                   rd_mux = 32'(period_q);
            ADDR_STATUS:                   rd_mux = 32'(out_port);
            default:                       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            readdata   <= '0;
        end else begin
            data_q <= data_d;
            if (wr_en && (address == ADDR_BLINK_EN)) begin
                blink_en_q <= wd_data;
            end
            if (period_wr) begin
                period_q <= wd_cnt;
            end
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    // A PERIOD write restarts the blink cycle even when it lands on a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (period_wr || (period_q == '0)) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            if (bcnt_q == period_q - CNT_W'(1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + CNT_W'(1);
            end
        end
    end

    assign out_port = data_q & ~(blink_en_q & {DATA_W{phase_q}});

endmodule

// File: tb/tb_pio_out_blink.sv
// Scoreboard bench for pio_out_blink: stimulus queues expectations, a negedge monitor checks them.
module tb_pio_out_blink;
    import pio_out_blink_pkg::*;

    typedef struct { string name; logic [31:0] exp; } rd_exp_t;
    typedef struct { string name; logic [9:0] exp; } port_exp_t;
    typedef struct { string name; int act; int lo; int hi; } misc_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    rd_exp_t   rd_q[$];
    port_exp_t port_q[$];
    misc_t     misc_q[$];

    int  n_cmp;
    int  n_bad;
    logic rd_seen;
    int  ecount;

    pio_out_blink #(
        .DATA_W      (10),
        .RESET_VALUE (10'h155),
        .PRESCALE    (4),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reads committed on this edge, and a model of the prescaler phase.
    always @(posedge clk) begin
        rd_seen <= reset_n && chipselect && !read_n;
        if (reset_n) ecount <= ecount + 1;
    end

    initial begin
        rd_exp_t   r;
        port_exp_t p;
        misc_t     m;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clk);
            if (rd_seen) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_read: readdata=%h, no read expected", readdata);
                end else begin
                    r = rd_q.pop_front();
                    if (readdata !== r.exp) begin
                        n_bad++;
                        $display("FAIL %s: readdata=%h, want %h", r.name, readdata, r.exp);
                    end
                end
            end
            while (port_q.size() > 0) begin
                p = port_q.pop_front();
                n_cmp++;
                if (out_port !== p.exp) begin
                    n_bad++;
                    $display("FAIL %s: out_port=%h, want %h", p.name, out_port, p.exp);
                end
            end
            while (misc_q.size() > 0) begin
                m = misc_q.pop_front();
                n_cmp++;
                if (m.act < m.lo || m.act > m.hi) begin
                    n_bad++;
                    $display("FAIL %s: got %0d, want %0d..%0d", m.name, m.act, m.lo, m.hi);
                end
            end
        end
    end

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
    endtask

    task automatic expect_port(input logic [9:0] ep, input string nm);
        port_q.push_back('{nm, ep});
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] wd,
                            input logic [9:0] ep, input string nm);
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = wd;
        @(posedge clk); #1;
        bus_idle();
        expect_port(ep, nm);
    endtask

    task automatic start_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        rd_q.push_back('{nm, exp});
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        start_read(a, exp, nm);
        @(posedge clk); #1;
        bus_idle();
    endtask

    initial begin
        int  d;
        logic found;
        ecount  = 0;
        rd_seen = 1'b0;
        reset_n = 1'b0;
        bus_idle();
        #2;
        expect_port(10'h155, "reset_port");
        misc_q.push_back('{"reset_readdata", int'(readdata), 0, 0});
        #10 reset_n = 1'b1;

        // Reset values
        do_read(ADDR_DATA, 32'h155, "rst_data_rd");
        do_read(ADDR_PERIOD, 32'h0, "rst_period_rd");
        do_read(ADDR_BLINK_EN, 32'h0, "rst_blink_en_rd");
        do_read(ADDR_STATUS, 32'h155, "rst_status_rd");

        // DATA / SET / CLEAR
        do_write(ADDR_DATA, 32'h0000_03F0, 10'h3F0, "data_wr");
        do_write(ADDR_SET, 32'h0000_000F, 10'h3FF, "set_wr");
        do_write(ADDR_CLR, 32'h0000_0300, 10'h0FF, "clr_wr");
        do_read(ADDR_DATA, 32'h0FF, "data_after_clr_rd");
        do_read(ADDR_SET, 32'h0FF, "set_alias_rd");
        do_read(ADDR_CLR, 32'h0FF, "clr_alias_rd");

        // Read directly after write sees new value
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_DATA; writedata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_idle();
        start_read(ADDR_DATA, 32'h3FF, "rd_after_wr");
        expect_port(10'h3FF, "wide_data_wr");
        @(posedge clk); #1;
        bus_idle();

        // Illegal simultaneous read/write: write commits, read sees old value
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
        address = ADDR_DATA; writedata = 32'h0;
        rd_q.push_back('{"rw_both_rd", 32'h3FF});
        @(posedge clk); #1;
        bus_idle();
        expect_port(10'h000, "rw_both_port");
        do_write(ADDR_DATA, 32'h0000_03FF, 10'h3FF, "data_restore");

        // Reserved / read-only addresses
        do_read(3'd6, 32'h0, "rsvd6_rd");
        do_read(3'd7, 32'h0, "rsvd7_rd");
        do_write(ADDR_STATUS, 32'hFFFF_FFFF, 10'h3FF, "status_wr_ignored");
        do_write(3'd6, 32'hFFFF_FFFF, 10'h3FF, "rsvd6_wr_ignored");
        do_read(ADDR_DATA, 32'h3FF, "data_after_rsvd_wr");
        do_read(ADDR_BLINK_EN, 32'h0, "blink_en_after_rsvd_wr");
        do_read(ADDR_PERIOD, 32'h0, "period_after_rsvd_wr");

        // Blink: PERIOD=2, PRESCALE=4 -> toggle every 8 cycles
        do_write(ADDR_BLINK_EN, 32'hFFFF_F003, 10'h3FF, "blink_en_wr");
        do_read(ADDR_BLINK_EN, 32'h003, "blink_en_rd");
        @(posedge clk); #1;
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_PERIOD; writedata = 32'h0001_0002;
        @(posedge clk); #1;
        bus_idle();
        d = 99;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            if (out_port !== 10'h3FF) begin
                found = 1'b1;
                d = i - 1;
            end
        end
        misc_q.push_back('{"first_toggle_delay", d, 5, 8});
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            bus_idle();
            if (i == 2) start_read(ADDR_STATUS, 32'h3FC, "status_phase1_rd");
            if (i == 4) start_read(ADDR_PERIOD, 32'h2, "period_rd");
            if (i == 10) start_read(ADDR_STATUS, 32'h3FF, "status_phase0_rd");
            expect_port((i >= 8 && i < 16) ? 10'h3FF : 10'h3FC, "blink_seq");
        end

        // PERIOD=0 while phase=1 stops blinking at once
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_PERIOD; writedata = 32'h0;
        @(posedge clk); #1;
        bus_idle();
        expect_port(10'h3FF, "period0_release");
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            expect_port(10'h3FF, "period0_hold");
        end

        // PERIOD=3 written on a tick edge: first toggle exactly 12 cycles later
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk); #1;
            if (ecount % 4 == 3) found = 1'b1;
        end
        chipselect = 1'b1; write_n = 1'b0; address = ADDR_PERIOD; writedata = 32'h3;
        @(posedge clk); #1;
        bus_idle();
        expect_port(10'h3FF, "tick_wr_port");
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            expect_port((i == 12) ? 10'h3FC : 10'h3FF, "tick_wr_seq");
        end
        do_read(ADDR_PERIOD, 32'h3, "period3_rd");

        repeat (2) @(posedge clk);
        #1;
        misc_q.push_back('{"pending_reads", rd_q.size(), 0, 0});
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
